// File: rtl/alu_pkg.sv
// Shared ALU/MDU control codes, ALUOp encodings and issue FSM state type.
package alu_pkg;

    localparam int ALUOP_W = 2;
    localparam int CODE_W  = 5;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [CODE_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [CODE_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [CODE_W-1:0] ALU_AND  = 5'd2;
    localparam logic [CODE_W-1:0] ALU_OR   = 5'd3;
    localparam logic [CODE_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [CODE_W-1:0] ALU_SLT  = 5'd5;
    localparam logic [CODE_W-1:0] ALU_SLL  = 5'd6;
    localparam logic [CODE_W-1:0] ALU_SRL  = 5'd7;
    localparam logic [CODE_W-1:0] ALU_SRA  = 5'd8;
    localparam logic [CODE_W-1:0] ALU_SLTU = 5'd9;

    // MDU codes are MDU_BASE + funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    localparam logic [CODE_W-1:0] MDU_BASE = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode-side handshake bundle: request fields in, registered control word out.
interface alu_issue_ctrl_if
    import alu_pkg::*;
#(
    parameter int CTRL_W = 5
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic               opb5;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               funct7b0;
    logic [ALUOP_W-1:0] ALUOp;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  ALUControl;
    logic               unit_sel;
    logic               illegal;

    modport master (
        output flush, in_valid, opb5, funct3, funct7b5, funct7b0, ALUOp, out_ready,
        input  in_ready, out_valid, ALUControl, unit_sel, illegal
    );

    modport slave (
        input  flush, in_valid, opb5, funct3, funct7b5, funct7b0, ALUOp, out_ready,
        output in_ready, out_valid, ALUControl, unit_sel, illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational funct/ALUOp -> control code, unit select, illegal and divide flags.
// Zero latency; no handshake.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter bit EN_MEXT = 1'b1
) (
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic               opb5,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               funct7b0,
    output logic [CODE_W-1:0]  code,
    output logic               unit_sel,
    output logic               illegal,
    output logic               is_mop,
    output logic               is_div
);

    always_comb begin
        code     = ALU_ADD;
        unit_sel = 1'b0;
        illegal  = 1'b0;
        is_mop   = 1'b0;
        is_div   = 1'b0;
        case (alu_op)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_RSVD: illegal = 1'b1;
            default: begin
                if (opb5 && funct7b0) begin
                    // M-extension space; SUB/SRA bit alongside it is not a valid encoding
                    if (funct7b5 || !EN_MEXT) begin
                        illegal = 1'b1;
                    end else begin
                        code     = MDU_BASE + {2'b00, funct3};
                        unit_sel = 1'b1;
                        is_mop   = 1'b1;
                        is_div   = funct3[2];
                    end
                end else begin
                    case (funct3)
                        3'b000:  code = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                        3'b001:  code = ALU_SLL;
                        3'b010:  code = ALU_SLT;
                        3'b011:  code = ALU_SLTU;
                        3'b100:  code = ALU_XOR;
                        3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
                        3'b110:  code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registered ALU/MDU issue controller: ALU ops 1 cycle, MUL 1+MUL_LAT, DIV/REM 1+DIV_LAT.
// in_ready low while BUSY or while a held result is not taken; outputs hold until out_ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter bit EN_MEXT = 1'b1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_issue_ctrl_if.slave  io
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               rdy_en;
    logic               out_vld_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic               unit_q;
    logic               ill_q;
    logic               accept;

    logic [CODE_W-1:0]  dec_code;
    logic               dec_unit;
    logic               dec_ill;
    logic               dec_mop;
    logic               dec_div;

    alu_op_decode #(.EN_MEXT(EN_MEXT)) u_dec (
        .alu_op   (io.ALUOp),
        .opb5     (io.opb5),
        .funct3   (io.funct3),
        .funct7b5 (io.funct7b5),
        .funct7b0 (io.funct7b0),
        .code     (dec_code),
        .unit_sel (dec_unit),
        .illegal  (dec_ill),
        .is_mop   (dec_mop),
        .is_div   (dec_div)
    );

    // rdy_en keeps in_ready low until the first edge after reset release
    assign io.in_ready = rdy_en && !io.flush &&
                         ((state == IDLE) || ((state == HOLD) && io.out_ready));
    assign accept      = io.in_valid && io.in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy_en    <= 1'b0;
            out_vld_q <= 1'b0;
            ctrl_q    <= '0;
            unit_q    <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (io.flush) begin
                state     <= IDLE;
                cnt       <= '0;
                out_vld_q <= 1'b0;
            end else if (accept) begin
                ctrl_q <= CTRL_W'(dec_code);
                unit_q <= dec_unit;
                ill_q  <= dec_ill;
                if (dec_mop) begin
                    state     <= BUSY;
                    cnt       <= dec_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                    out_vld_q <= 1'b0;
                end else begin
                    state     <= HOLD;
                    out_vld_q <= 1'b1;
                end
            end else begin
                case (state)
                    BUSY: begin
                        if (cnt == CNT_W'(1)) begin
                            state     <= HOLD;
                            cnt       <= '0;
                            out_vld_q <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    HOLD: begin
                        if (io.out_ready) begin
                            state     <= IDLE;
                            out_vld_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io.out_valid  = out_vld_q;
    assign io.ALUControl = ctrl_q;
    assign io.unit_sel   = unit_q;
    assign io.illegal    = ill_q;

endmodule
